// File: rtl/iob_uart_tester_pkg.sv
// Shared types and defaults for the IOb tester-UART bridge: FSM encoding,
// UART register offsets, end-of-transmission byte and byte-0 write strobe.
package iob_uart_tester_pkg;

    typedef enum logic [3:0] {
        IDLE,
        TXQ_REQ,
        TXQ_WAIT,
        TXW_REQ,
        RXQ_REQ,
        RXQ_WAIT,
        RXR_REQ,
        RXR_WAIT,
        NEXT
    } state_t;

    localparam int TXREADY_ADDR_DEF = 0;
    localparam int RXREADY_ADDR_DEF = 1;
    localparam int TXDATA_ADDR_DEF  = 2;
    localparam int RXDATA_ADDR_DEF  = 3;

    localparam logic [7:0] EOT_BYTE_DEF = 8'h04;
    localparam logic [3:0] WSTRB_BYTE0  = 4'b0001;

endpackage

// File: rtl/iob_uart_tester_fifo.sv
// Per-channel RX byte FIFO, depth 2^DEPTH_LOG2, with full/empty/level status.
module iob_uart_tester_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  push,
    input  logic [7:0]            din,
    input  logic                  pop,
    output logic [7:0]            dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = (level == (DEPTH_LOG2 + 1)'(DEPTH));

    // A push into a full FIFO is taken only alongside a pop: the head slot is
    // read out and rewritten on the same edge, so occupancy stays at DEPTH.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end

    assign dout = mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/iob_uart_tester_bridge.sv
// Round-robin IOb master that polls NCH tester UARTs, forwarding TX bytes and
// draining RX bytes into per-channel FIFOs. Optional watchdog: IOB_UART_TESTER_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | decide what to do for the current channel
// TXQ_REQ  | read TXREADY of the channel
// TXQ_WAIT | wait for TXREADY read data
// TXW_REQ  | write the held TX byte to TXDATA
// RXQ_REQ  | read RXREADY of the channel
// RXQ_WAIT | wait for RXREADY read data
// RXR_REQ  | read RXDATA of the channel
// RXR_WAIT | wait for RXDATA read data, push into FIFO
// NEXT     | advance the channel pointer
module iob_uart_tester_bridge
    import iob_uart_tester_pkg::*;
#(
    parameter int                    NCH           = 2,
    parameter int                    CH_W          = 3,
    parameter int                    REG_ADDR_W    = 3,
    parameter int                    DATA_W        = 32,
    parameter int                    RX_DEPTH_LOG2 = 4,
    parameter logic [REG_ADDR_W-1:0] TXREADY_ADDR  = REG_ADDR_W'(TXREADY_ADDR_DEF),
    parameter logic [REG_ADDR_W-1:0] RXREADY_ADDR  = REG_ADDR_W'(RXREADY_ADDR_DEF),
    parameter logic [REG_ADDR_W-1:0] TXDATA_ADDR   = REG_ADDR_W'(TXDATA_ADDR_DEF),
    parameter logic [REG_ADDR_W-1:0] RXDATA_ADDR   = REG_ADDR_W'(RXDATA_ADDR_DEF),
    parameter logic [7:0]            EOT_BYTE      = EOT_BYTE_DEF,
    parameter int                    TIMEOUT_CYC   = 1024
) (
    input  logic                         clk_i,
    input  logic                         arst_n_i,
    input  logic [NCH-1:0]               tx_valid_i,
    input  logic [8*NCH-1:0]             tx_data_i,
    output logic [NCH-1:0]               tx_ready_o,
    output logic [NCH-1:0]               rx_valid_o,
    output logic [8*NCH-1:0]             rx_data_o,
    input  logic [NCH-1:0]               rx_ready_i,
    output logic [NCH-1:0]               eot_o,
    output logic                         iob_avalid_o,
    output logic [CH_W+REG_ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]            iob_wdata_o,
    output logic [DATA_W/8-1:0]          iob_wstrb_o,
    input  logic [DATA_W-1:0]            iob_rdata_i,
    input  logic                         iob_ready_i,
    input  logic                         iob_rvalid_i,
    output logic                         err_o
);

    localparam int IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int STRB_W = DATA_W / 8;

    state_t                        state;
    state_t                        state_nx;
    logic [IDX_W-1:0]              ch;
    logic [NCH-1:0]                tx_hold_valid;
    logic [7:0]                    tx_hold_data [NCH];
    logic [NCH-1:0]                fifo_full;
    logic [NCH-1:0]                fifo_empty;
    logic [NCH-1:0][RX_DEPTH_LOG2:0] fifo_level;
    logic [NCH-1:0]                eot_q;
    logic                          rd_bit;
    logic                          rx_space;
    logic                          tx_wr_done;
    logic                          rx_byte_vld;
    logic                          tmo;
    state_t                        rx_chk;

    assign rd_bit      = iob_rdata_i[0];
    assign rx_space    = !fifo_full[ch];
    assign rx_chk      = rx_space ? RXQ_REQ : NEXT;
    assign tx_wr_done  = (state == TXW_REQ) && iob_ready_i;
    assign rx_byte_vld = (((state == RXR_REQ) && iob_ready_i) || (state == RXR_WAIT)) && iob_rvalid_i;

    assign tx_ready_o = ~tx_hold_valid;
    assign rx_valid_o = ~fifo_empty;
    assign eot_o      = eot_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= IDLE;
            ch    <= '0;
        end else begin
            state <= state_nx;
            if (state == NEXT) ch <= (ch == IDX_W'(NCH - 1)) ? '0 : ch + 1'b1;
        end
    end

    // Reads complete on rvalid, which may coincide with ready or trail it.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = tx_hold_valid[ch] ? TXQ_REQ : rx_chk;
            TXQ_REQ:  if (iob_ready_i) begin
                          if (iob_rvalid_i) state_nx = rd_bit ? TXW_REQ : rx_chk;
                          else              state_nx = TXQ_WAIT;
                      end
            TXQ_WAIT: if (iob_rvalid_i) state_nx = rd_bit ? TXW_REQ : rx_chk;
            TXW_REQ:  if (iob_ready_i) state_nx = rx_chk;
            RXQ_REQ:  if (iob_ready_i) begin
                          if (iob_rvalid_i) state_nx = rd_bit ? RXR_REQ : NEXT;
                          else              state_nx = RXQ_WAIT;
                      end
            RXQ_WAIT: if (iob_rvalid_i) state_nx = rd_bit ? RXR_REQ : NEXT;
            RXR_REQ:  if (iob_ready_i) state_nx = iob_rvalid_i ? NEXT : RXR_WAIT;
            RXR_WAIT: if (iob_rvalid_i) state_nx = NEXT;
            NEXT:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        if (tmo) state_nx = NEXT;
    end

    always_comb begin
        iob_avalid_o = 1'b0;
        iob_addr_o   = '0;
        iob_wdata_o  = '0;
        iob_wstrb_o  = '0;
        case (state)
            TXQ_REQ: begin
                iob_avalid_o = 1'b1;
                iob_addr_o   = {CH_W'(ch), TXREADY_ADDR};
            end
            TXW_REQ: begin
                iob_avalid_o = 1'b1;
                iob_addr_o   = {CH_W'(ch), TXDATA_ADDR};
                iob_wdata_o  = DATA_W'(tx_hold_data[ch]);
                iob_wstrb_o  = STRB_W'(WSTRB_BYTE0);
            end
            RXQ_REQ: begin
                iob_avalid_o = 1'b1;
                iob_addr_o   = {CH_W'(ch), RXREADY_ADDR};
            end
            RXR_REQ: begin
                iob_avalid_o = 1'b1;
                iob_addr_o   = {CH_W'(ch), RXDATA_ADDR};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            tx_hold_valid <= '0;
            eot_q         <= '0;
            for (int k = 0; k < NCH; k++) tx_hold_data[k] <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (tx_valid_i[k] && !tx_hold_valid[k]) begin
                    tx_hold_valid[k] <= 1'b1;
                    tx_hold_data[k]  <= tx_data_i[8*k +: 8];
                end else if ((tx_wr_done || tmo) && (ch == IDX_W'(k))) begin
                    tx_hold_valid[k] <= 1'b0;
                end
            end
            if (rx_byte_vld && (iob_rdata_i[7:0] == EOT_BYTE)) eot_q[ch] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_rx_fifo
        iob_uart_tester_fifo #(
            .DEPTH_LOG2 (RX_DEPTH_LOG2)
        ) u_fifo (
            .clk    (clk_i),
            .arst_n (arst_n_i),
            .push   (rx_byte_vld && (ch == IDX_W'(k))),
            .din    (iob_rdata_i[7:0]),
            .pop    (rx_ready_i[k]),
            .dout   (rx_data_o[8*k +: 8]),
            .full   (fifo_full[k]),
            .empty  (fifo_empty[k]),
            .level  (fifo_level[k])
        );
    end

`ifdef IOB_UART_TESTER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;

    logic [TMR_W-1:0] tmr;
    logic             busy;
    logic             err_q;

    assign busy  = (state != IDLE) && (state != NEXT);
    assign tmo   = busy && (tmr == '0);
    assign err_o = err_q;

    // Down-counter reloads on every state change, so each REQ/WAIT gets its own budget.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            tmr   <= TMR_W'(TIMEOUT_CYC - 1);
            err_q <= 1'b0;
        end else begin
            if (!busy || (state_nx != state)) tmr <= TMR_W'(TIMEOUT_CYC - 1);
            else if (tmr != '0)               tmr <= tmr - 1'b1;
            if (tmo) err_q <= 1'b1;
        end
    end
`else
    logic unused_tmo;

    assign tmo        = 1'b0;
    assign err_o      = 1'b0;
    assign unused_tmo = ^TIMEOUT_CYC;
`endif

    logic unused_bits;
    assign unused_bits = ^{iob_rdata_i[DATA_W-1:8], fifo_level};

endmodule

// File: tb/tb_iob_uart_tester_bridge.sv
// Bench for iob_uart_tester_bridge: behavioural tester-UART responder on the
// IOb port with per-channel TX/RX scoreboards.
module tb_iob_uart_tester_bridge;

    localparam int NCH = 2;
    localparam int TMO = 16;

    logic              clk_i = 1'b0;
    logic              arst_n_i;
    logic [NCH-1:0]    tx_valid_i;
    logic [8*NCH-1:0]  tx_data_i;
    logic [NCH-1:0]    tx_ready_o;
    logic [NCH-1:0]    rx_valid_o;
    logic [8*NCH-1:0]  rx_data_o;
    logic [NCH-1:0]    rx_ready_i;
    logic [NCH-1:0]    eot_o;
    logic              iob_avalid_o;
    logic [5:0]        iob_addr_o;
    logic [31:0]       iob_wdata_o;
    logic [3:0]        iob_wstrb_o;
    logic [31:0]       iob_rdata_i;
    logic              iob_ready_i;
    logic              iob_rvalid_i;
    logic              err_o;

    iob_uart_tester_bridge #(
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i        (clk_i),
        .arst_n_i     (arst_n_i),
        .tx_valid_i   (tx_valid_i),
        .tx_data_i    (tx_data_i),
        .tx_ready_o   (tx_ready_o),
        .rx_valid_o   (rx_valid_o),
        .rx_data_o    (rx_data_o),
        .rx_ready_i   (rx_ready_i),
        .eot_o        (eot_o),
        .iob_avalid_o (iob_avalid_o),
        .iob_addr_o   (iob_addr_o),
        .iob_wdata_o  (iob_wdata_o),
        .iob_wstrb_o  (iob_wstrb_o),
        .iob_rdata_i  (iob_rdata_i),
        .iob_ready_i  (iob_ready_i),
        .iob_rvalid_i (iob_rvalid_i),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // UART model state and scoreboards
    int         ready_dly = 0;
    int         rv_dly    = 0;
    bit         stuck     = 1'b0;
    int         txrdy_hold [NCH];
    int         rxq_reads  [NCH];
    logic [7:0] rx_src [NCH][$];
    logic [7:0] rx_exp [NCH][$];
    logic [7:0] tx_exp [NCH][$];

    initial begin : responder
        int          cnt;
        bit          pend;
        int          pcnt;
        int          c;
        logic [31:0] pdata;
        logic [5:0]  lat_addr;
        logic [31:0] lat_wdata;
        logic [2:0]  rg;
        cnt = 0; pend = 1'b0; pcnt = 0; pdata = '0; lat_addr = '0; lat_wdata = '0;
        iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = '0;
        forever begin
            tick();
            iob_ready_i  = 1'b0;
            iob_rvalid_i = 1'b0;
            if (!arst_n_i) begin
                cnt = 0; pend = 1'b0;
            end else if (pend) begin
                pcnt--;
                if (pcnt <= 0) begin
                    iob_rvalid_i = 1'b1; iob_rdata_i = pdata; pend = 1'b0;
                end
            end else if (iob_avalid_o) begin
                if (cnt == 0) begin
                    lat_addr = iob_addr_o; lat_wdata = iob_wdata_o;
                end else begin
                    chk("addr_hold", 32'(iob_addr_o), 32'(lat_addr));
                    chk("wdata_hold", iob_wdata_o, lat_wdata);
                end
                if (!stuck && cnt >= ready_dly) begin
                    cnt = 0;
                    iob_ready_i = 1'b1;
                    c  = int'(iob_addr_o[5:3]);
                    rg = iob_addr_o[2:0];
                    if (c >= NCH) begin
                        chk("addr_ch", 32'(c), 32'(NCH - 1));
                        c = 0;
                    end
                    if (iob_wstrb_o != 4'b0000) begin
                        chk("tx_reg", 32'(rg), 32'd2);
                        chk("tx_strb", 32'(iob_wstrb_o), 32'b0001);
                        if (tx_exp[c].size() > 0) chk("tx_byte", 32'(iob_wdata_o[7:0]), 32'(tx_exp[c].pop_front()));
                        else                      chk("tx_pending", 32'(tx_exp[c].size()), 32'd1);
                    end else begin
                        pdata = $urandom();
                        case (rg)
                            3'd0: begin
                                if (txrdy_hold[c] > 0) begin pdata[0] = 1'b0; txrdy_hold[c]--; end
                                else pdata[0] = 1'b1;
                            end
                            3'd1: begin
                                rxq_reads[c]++;
                                pdata[0] = (rx_src[c].size() != 0);
                            end
                            3'd3: begin
                                if (rx_src[c].size() > 0) pdata[7:0] = rx_src[c].pop_front();
                                else                      chk("rx_src_empty", 32'(rx_src[c].size()), 32'd1);
                            end
                            default: chk("rd_reg", 32'(rg), 32'd0);
                        endcase
                        if (rv_dly == 0) begin
                            iob_rvalid_i = 1'b1; iob_rdata_i = pdata;
                        end else begin
                            pend = 1'b1; pcnt = rv_dly;
                        end
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // RX pop monitor: a pop happens at the next edge when valid & ready
    always @(negedge clk_i) begin
        if (arst_n_i) begin
            for (int k = 0; k < NCH; k++) begin
                if (rx_valid_o[k] && rx_ready_i[k]) begin
                    if (rx_exp[k].size() > 0) chk("rx_byte", 32'(rx_data_o[8*k +: 8]), 32'(rx_exp[k].pop_front()));
                    else                      chk("rx_extra", 32'(rx_exp[k].size()), 32'd1);
                end
            end
        end
    end

    task automatic send_tx(input int c, input logic [7:0] b);
        for (int i = 0; i < 2000 && !tx_ready_o[c]; i++) tick();
        chk("tx_rdy_before", 32'(tx_ready_o[c]), 32'd1);
        tx_valid_i[c] = 1'b1;
        tx_data_i[8*c +: 8] = b;
        tx_exp[c].push_back(b);
        tick();
        tx_valid_i[c] = 1'b0;
        chk("tx_rdy_drop", 32'(tx_ready_o[c]), 32'd0);
    endtask

    task automatic push_rx(input int c, input logic [7:0] b);
        rx_src[c].push_back(b);
        rx_exp[c].push_back(b);
    endtask

    initial begin : watchdog
        #800_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        int first_ch;
        int n;
        for (int k = 0; k < NCH; k++) begin txrdy_hold[k] = 0; rxq_reads[k] = 0; end
        arst_n_i = 1'b0; tx_valid_i = '0; tx_data_i = '0; rx_ready_i = '0;
        repeat (3) tick();
        chk("rst_tx_ready", 32'(tx_ready_o), 32'b11);
        chk("rst_rx_valid", 32'(rx_valid_o), 32'b00);
        chk("rst_avalid", 32'(iob_avalid_o), 32'd0);
        chk("rst_addr", 32'(iob_addr_o), 32'd0);
        chk("rst_wstrb", 32'(iob_wstrb_o), 32'd0);
        chk("rst_eot", 32'(eot_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        arst_n_i = 1'b1;
        tick();

        // TX on channel 1 with TXREADY low for the first three polls
        txrdy_hold[1] = 3;
        send_tx(1, 8'h41);
        for (int i = 0; i < 1000 && !(tx_exp[1].size() == 0 && tx_ready_o[1]); i++) tick();
        chk("tx1_written", 32'(tx_exp[1].size()), 32'd0);
        chk("tx1_ready_back", 32'(tx_ready_o[1]), 32'd1);
        chk("txrdy_polls_used", 32'(txrdy_hold[1]), 32'd0);

        // RX on channel 0 ending with EOT
        chk("eot_before", 32'(eot_o), 32'd0);
        push_rx(0, 8'h55); push_rx(0, 8'hAA); push_rx(0, 8'h04);
        rx_ready_i[0] = 1'b1;
        for (int i = 0; i < 2000 && rx_exp[0].size() != 0; i++) tick();
        chk("rx0_drained", 32'(rx_exp[0].size()), 32'd0);
        tick();
        chk("eot_after", 32'(eot_o), 32'b01);

        // Fill channel 0 FIFO, check polling stops for it only
        rx_ready_i[0] = 1'b0;
        for (int i = 0; i < 18; i++) push_rx(0, 8'h10 + 8'(i));
        for (int i = 0; i < 3000 && rx_src[0].size() > 2; i++) tick();
        repeat (20) tick();
        chk("fill_src_left", 32'(rx_src[0].size()), 32'd2);
        chk("fill_rx_valid", 32'(rx_valid_o[0]), 32'd1);
        rxq_reads[0] = 0;
        push_rx(1, 8'h61); push_rx(1, 8'h62);
        rx_ready_i[1] = 1'b1;
        for (int i = 0; i < 2000 && rx_exp[1].size() != 0; i++) tick();
        chk("ch1_serviced", 32'(rx_exp[1].size()), 32'd0);
        repeat (50) tick();
        chk("no_poll_full", 32'(rxq_reads[0]), 32'd0);
        chk("full_src_kept", 32'(rx_src[0].size()), 32'd2);
        rx_ready_i[0] = 1'b1;
        for (int i = 0; i < 3000 && rx_exp[0].size() != 0; i++) tick();
        chk("ch0_resumed", 32'(rx_exp[0].size()), 32'd0);
        chk("ch0_polled", 32'(rxq_reads[0] > 0), 32'd1);

        // Slow IOb slave: ready after 5 cycles, rvalid 2 cycles later
        ready_dly = 5; rv_dly = 2;
        txrdy_hold[1] = 1;
        push_rx(1, 8'h33); push_rx(1, 8'hC3);
        send_tx(0, 8'h5A);
        send_tx(1, 8'hE7);
        for (int i = 0; i < 5000 && !(tx_exp[0].size() == 0 && tx_exp[1].size() == 0 &&
                                      rx_exp[1].size() == 0 && tx_ready_o == 2'b11); i++) tick();
        chk("slow_tx0", 32'(tx_exp[0].size()), 32'd0);
        chk("slow_tx1", 32'(tx_exp[1].size()), 32'd0);
        chk("slow_rx1", 32'(rx_exp[1].size()), 32'd0);
        chk("slow_tx_ready", 32'(tx_ready_o), 32'b11);

        // rvalid one cycle after ready
        ready_dly = 0; rv_dly = 1;
        push_rx(0, 8'h7E);
        send_tx(0, 8'h21);
        for (int i = 0; i < 2000 && !(tx_exp[0].size() == 0 && rx_exp[0].size() == 0); i++) tick();
        chk("rv1_tx0", 32'(tx_exp[0].size()), 32'd0);
        chk("rv1_rx0", 32'(rx_exp[0].size()), 32'd0);
        rv_dly = 0;
        repeat (10) tick();
        chk("eot_final", 32'(eot_o), 32'b01);
        chk("err_clear", 32'(err_o), 32'd0);

`ifdef IOB_UART_TESTER_TIMEOUT_EN
        stuck = 1'b1;
        for (int i = 0; i < 100 && iob_avalid_o; i++) tick();
        for (int i = 0; i < 100 && !iob_avalid_o; i++) tick();
        chk("tmo_req_seen", 32'(iob_avalid_o), 32'd1);
        first_ch = int'(iob_addr_o[5:3]);
        n = 0;
        while (iob_avalid_o && n < 200) begin
            n++;
            tick();
        end
        chk("tmo_len", 32'(n), 32'(TMO));
        chk("tmo_err", 32'(err_o), 32'd1);
        for (int i = 0; i < 100 && !iob_avalid_o; i++) tick();
        chk("tmo_next_ch", 32'(iob_addr_o[5:3]), 32'((first_ch + 1) % NCH));
        arst_n_i = 1'b0;
        tick();
        chk("tmo_rst_err", 32'(err_o), 32'd0);
        chk("tmo_rst_avalid", 32'(iob_avalid_o), 32'd0);
        stuck = 1'b0;
        arst_n_i = 1'b1;
        repeat (5) tick();
`else
        first_ch = 0;
        n = 0;
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/iob_uart_tester_bridge.md
Name: iob_uart_tester_bridge

Overview:
- Testbench-side bridge that lets a simulation wrapper drive NCH tester UART cores through byte streams instead of raw IOb register accesses.
- One IOb-native master port polls each tester UART round-robin, forwards TX bytes and drains RX bytes into per-channel FIFOs.
- Flags end-of-transmission (EOT) per channel so the wrapper can end simulation.
- Successor to the single hand-driven tester UART in the SoC sim wrapper.

Parameters:
- NCH, 2, number of tester UART channels (1..8).
- CH_W, 3, channel-select bits prepended to the register address (2^CH_W >= NCH).
- REG_ADDR_W, 3, UART register address width.
- DATA_W, 32, IOb data width.
- RX_DEPTH_LOG2, 4, per-channel RX FIFO depth (2^N entries).
- TXREADY_ADDR / RXREADY_ADDR / TXDATA_ADDR / RXDATA_ADDR, 0/1/2/3, UART register offsets.
- EOT_BYTE, 8'h04, byte that sets eot_o.
- TIMEOUT_CYC, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  system clock.
- arst_n_i  in  1  reset, asynchronous and active-low.
- tx_valid_i  in  NCH  per-channel TX byte valid.
- tx_data_i  in  8*NCH  per-channel TX bytes; channel k occupies [8k+7:8k].
- tx_ready_o  out  NCH  TX holding register empty.
- rx_valid_o  out  NCH  RX FIFO not empty.
- rx_data_o  out  8*NCH  RX FIFO heads.
- rx_ready_i  in  NCH  pop RX FIFO.
- eot_o  out  NCH  sticky: EOT_BYTE received on that channel.
- iob_avalid_o  out  1  IOb request valid.
- iob_addr_o  out  CH_W+REG_ADDR_W  address = {channel, register offset}.
- iob_wdata_o  out  DATA_W  write data; byte in [7:0].
- iob_wstrb_o  out  DATA_W/8  4'b0001 on writes, 0 on reads.
- iob_rdata_i  in  DATA_W  read data.
- iob_ready_i  in  1  request accepted.
- iob_rvalid_i  in  1  read data valid.
- err_o  out  1  sticky timeout error; tied 0 when the feature is off.

Behaviour:
- Reset (arst_n_i=0, async):
  - State IDLE, channel pointer 0.
  - iob_avalid_o=0; iob_addr_o, iob_wdata_o and iob_wstrb_o = 0.
  - tx_ready_o all 1; rx_valid_o all 0; eot_o = 0; err_o = 0; FIFOs empty.
- TX holding register per channel: loaded when tx_valid_i & tx_ready_o; tx_ready_o drops the next cycle and rises one cycle after the byte-write IOb handshake.
- IOb rules:
  - avalid, addr, wdata and wstrb held stable until iob_ready_i=1.
  - Writes complete on ready.
  - Reads wait for iob_rvalid_i; rvalid may arrive the same cycle as ready or later. Only one outstanding request.
- FSM states: IDLE, TXQ_REQ, TXQ_WAIT, TXW_REQ, RXQ_REQ, RXQ_WAIT, RXR_REQ, RXR_WAIT, NEXT.
- IDLE:
  - If channel c has TX pending -> TXQ_REQ (read TXREADY_ADDR).
  - Else if FIFO c has space for 1 entry -> RXQ_REQ (read RXREADY_ADDR).
  - Else -> NEXT.
- TXQ_WAIT:
  - rdata[0]=1 -> TXW_REQ (write TXDATA_ADDR).
  - rdata[0]=0 -> RXQ check, same as IDLE without TX.
- TXW_REQ complete -> RXQ check.
- RXQ_WAIT:
  - rdata[0]=1 -> RXR_REQ (read RXDATA_ADDR).
  - rdata[0]=0 -> NEXT.
- RXR_WAIT: push rdata[7:0] into FIFO c -> NEXT. If the byte equals EOT_BYTE, set eot_o[c].
- NEXT: c <= (c==NCH-1) ? 0 : c+1 -> IDLE. At most one TX and one RX byte per channel per visit.
- FIFO: full blocks RX polling for that channel only. A simultaneous push and pop on a full or empty FIFO is legal; occupancy stays correct.
- Reset mid-transaction: avalid drops immediately; a partially polled byte is lost; TX holding register cleared.

Optional Feature:
- Macro IOB_UART_TESTER_TIMEOUT_EN.
- Defined:
  - Counter runs while in any *_REQ or *_WAIT state; it resets on every state change.
  - On reaching TIMEOUT_CYC: deassert avalid, set err_o sticky, clear the current channel's TX holding register, go to NEXT.
- Undefined: no counter; err_o tied 0; the bridge waits indefinitely.

Decomposition:
- Package iob_uart_tester_pkg: FSM state encoding, register-offset defaults, EOT default, wstrb constant.
- Sub-module iob_uart_tester_fifo: synchronous FIFO, 8-bit, depth 2^RX_DEPTH_LOG2, with full/empty/level outputs. Instantiated NCH times via generate.

Test Plan:
- Reset with NCH=2 -> tx_ready_o=2'b11, rx_valid_o=0, iob_avalid_o=0, eot_o=0.
- Channel 1 sends 8'h41; model UART returns TXREADY=1 after 3 cycles -> write to addr {1,TXDATA_ADDR}, wdata[7:0]=8'h41, wstrb=4'b0001; tx_ready_o[1] returns to 1.
- Channel 0 model returns RXREADY=1, then RXDATA=0x55, 0xAA, 0x04 -> rx_data_o[7:0] pops 0x55, 0xAA, 0x04 in order; eot_o[0]=1 after the third byte.
- rx_ready_i held 0 with 16 bytes queued on channel 0 -> no further RXREADY reads to channel 0; channel 1 is still serviced; popping one byte resumes polling of channel 0.
- iob_ready_i delayed 5 cycles and rvalid delayed a further 2 -> addr/avalid stable throughout; correct bytes delivered.
- With IOB_UART_TESTER_TIMEOUT_EN and TIMEOUT_CYC=16, iob_ready_i stuck at 0 -> err_o=1 at cycle 16; FSM advances to the next channel; reset clears err_o.
